// File: rtl/line_buffer_3row.sv
// 3-row line buffer: emits a vertical 3-pixel column per streamed pixel.
// Ports: clk, reset (async low), start, in_valid/pixel_in in; pixel_out0..2, out_valid, busy, frame_done out.
module line_buffer_3row #(
  parameter int BIT_LENGTH = 5,
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [BIT_LENGTH-1:0] pixel_in,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0] col, col_n, pcol;
  logic [RW-1:0] row, row_n, prow;
  logic          accept, last_col, emit, last_pix;

  logic [BIT_LENGTH-1:0] mem0 [IMG_WIDTH];
  logic [BIT_LENGTH-1:0] mem1 [IMG_WIDTH];

  // start re-aims the current pixel at (0,0) of a new frame
  always_comb begin
    state_n  = state;
    pcol     = start ? '0 : col;
    prow     = start ? '0 : row;
    col_n    = pcol;
    row_n    = prow;
    accept   = in_valid &&
               (start || state == FILL || state == STREAM);
    last_col = (pcol == CW'(IMG_WIDTH - 1));
    emit     = accept && (prow >= RW'(2));
    last_pix = accept && last_col &&
               (prow == RW'(IMG_HEIGHT - 1));
    if (start) begin
      state_n = FILL;
    end
    if (accept) begin
      if (last_col) begin
        col_n = '0;
        row_n = prow + RW'(1);
      end else begin
        col_n = pcol + CW'(1);
      end
      if (last_col && prow == RW'(1)) begin
        state_n = STREAM;
      end
      if (last_pix) begin
        state_n = DONE;
        row_n   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      pixel_out0 <= '0;
      pixel_out1 <= '0;
      pixel_out2 <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      col        <= col_n;
      row        <= row_n;
      out_valid  <= emit;
      frame_done <= last_pix;
      // stays high through the frame_done cycle
      busy       <= (state_n == FILL) ||
                    (state_n == STREAM) || last_pix;
      if (emit) begin
        pixel_out0 <= mem0[pcol];
        pixel_out1 <= mem1[pcol];
        pixel_out2 <= pixel_in;
      end
    end
  end

  // rows shift up one slot per accepted column
  always_ff @(posedge clk) begin
    if (accept) begin
      mem0[pcol] <= mem1[pcol];
      mem1[pcol] <= pixel_in;
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Self-checking bench for line_buffer_3row (4x4 image, 5-bit pixels).
// Table vectors, directed corner sequences and a random run vs a frame model.
module tb_line_buffer_3row;

  localparam int B = 5;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic         clk = 0;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic [B-1:0] pixel_in;
  logic [B-1:0] pixel_out0, pixel_out1, pixel_out2;
  logic         out_valid, busy, frame_done;

  int checks = 0;
  int errors = 0;

  line_buffer_3row #(
    .BIT_LENGTH(B),
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .pixel_in  (pixel_in),
    .pixel_out0(pixel_out0),
    .pixel_out1(pixel_out1),
    .pixel_out2(pixel_out2),
    .out_valid (out_valid),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // frame model: pixels of the current frame indexed in raster order
  logic [B-1:0] frm [N];
  logic         armed;
  int           n;
  logic [B-1:0] e0, e1, e2;
  logic         eov, efd, ebusy;

  task automatic model_reset();
    armed = 0; n = 0;
    e0 = 0; e1 = 0; e2 = 0;
    eov = 0; efd = 0; ebusy = 0;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_dut();
    return {16'd0, out_valid, frame_done, busy,
            pixel_out0, pixel_out1, pixel_out2};
  endfunction

  function automatic logic [31:0] pack_exp();
    return {16'd0, eov, efd, ebusy, e0, e1, e2};
  endfunction

  task automatic step(input logic s, input logic v,
                      input logic [B-1:0] p);
    start = s; in_valid = v; pixel_in = p;
    @(posedge clk);
    #1;
    eov = 0; efd = 0;
    if (s) begin
      armed = 1; n = 0;
    end
    if (v && armed) begin
      frm[n] = p;
      if (n >= 2 * W) begin
        e0 = frm[n - 2 * W];
        e1 = frm[n - W];
        e2 = p;
        eov = 1;
      end
      if (n == N - 1) begin
        efd = 1; armed = 0;
      end
      n++;
    end
    ebusy = armed || efd;
    check("model", pack_dut(), pack_exp());
    start = 0; in_valid = 0;
  endtask

  typedef struct {
    logic         s, v;
    logic [B-1:0] p;
    logic         ov, fd, bz;
    logic [B-1:0] o0, o1, o2;
  } vec_t;

  vec_t tbl [N + 2];
  int   ovcnt;
  logic seen;

  initial begin
    // table for back-to-back frame of pixels 0..15
    tbl[0] = '{1, 0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < N; i++) begin
      tbl[i + 1] = '{0, 1, B'(i), 0, 0, 1, 0, 0, 0};
      if (i >= 2 * W) begin
        tbl[i + 1].ov = 1;
        tbl[i + 1].o0 = B'(i - 8);
        tbl[i + 1].o1 = B'(i - 4);
        tbl[i + 1].o2 = B'(i);
      end else begin
        tbl[i + 1].o0 = 0;
        tbl[i + 1].o1 = 0;
        tbl[i + 1].o2 = 0;
      end
    end
    tbl[N].fd = 1;
    tbl[N + 1] = '{0, 0, 0, 0, 0, 0, 7, 11, 15};

    start = 0; in_valid = 0; pixel_in = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack_dut(), 32'd0);
    reset = 1;

    // idle ignores pixels
    step(0, 1, 5);
    step(0, 1, 6);

    for (int i = 0; i < N + 2; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].p);
      check($sformatf("tbl%0d", i), pack_dut(),
            {16'd0, tbl[i].ov, tbl[i].fd, tbl[i].bz,
             tbl[i].o0, tbl[i].o1, tbl[i].o2});
    end

    // gapped stream
    ovcnt = 0;
    step(1, 0, 0);
    for (int i = 0; i < N; i++) begin
      step(0, 1, B'(i));
      ovcnt += int'(out_valid);
      step(0, 0, B'(31));
      check("gap_ov", {31'd0, out_valid}, 32'd0);
    end
    check("gap_count", ovcnt, (H - 2) * W);

    // pixels after done without start
    for (int i = 0; i < 5; i++) step(0, 1, B'(i + 3));
    check("hold_after_done",
          {pixel_out0, pixel_out1, pixel_out2},
          {B'(7), B'(11), B'(15)});

    // restart mid-frame with a same-cycle pixel
    step(1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, B'(i));
    step(1, 1, B'(20));
    seen = 0;
    for (int i = 21; i <= 35; i++) begin
      step(0, 1, B'(i));
      if (out_valid && !seen) begin
        seen = 1;
        check("restart_first",
              {pixel_out0, pixel_out1, pixel_out2},
              {B'(20), B'(24), B'(28)});
      end
    end
    check("restart_seen", {31'd0, seen}, 32'd1);

    // async reset during pixel 10
    step(1, 0, 0);
    for (int i = 0; i <= 10; i++) step(0, 1, B'(i));
    #2;
    reset = 0;
    #1;
    model_reset();
    check("async_reset", pack_dut(), 32'd0);
    @(posedge clk);
    #3;
    reset = 1;
    for (int i = 0; i < 6; i++) step(0, 1, B'(i + 9));
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, B'(i + 1));

    // constant-17 frame
    step(1, 0, 0);
    for (int i = 0; i < N; i++) step(0, 1, B'(17));
    check("const17",
          {pixel_out0, pixel_out1, pixel_out2},
          {B'(17), B'(17), B'(17)});

    // random traffic, including starts in every state
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0,
           B'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
